// File: rtl/uart_rx_if.sv
// uart_rx_if: serial-side and FIFO-side signals of the oversampling UART receiver
// slave  (receiver): takes rx, s_tick; drives dout, rx_done_tick, frame_err, busy
// master (driver/observer): the mirror image
interface uart_rx_if #(
  parameter int DBIT = 8
);
  logic            rx;
  logic            s_tick;
  logic [DBIT-1:0] dout;
  logic            rx_done_tick;
  logic            frame_err;
  logic            busy;
  modport master (output rx, s_tick, input dout, rx_done_tick, frame_err, busy);
  modport slave  (input rx, s_tick, output dout, rx_done_tick, frame_err, busy);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampling UART receiver producing one FIFO write strobe per frame
// clk/reset      : system clock, synchronous active-high reset
// u.rx           : asynchronous serial input (idles high), 2-flop synchronised
// u.s_tick       : oversample enable, OS ticks per bit
// u.dout         : last received word, LSB first on the wire
// u.rx_done_tick : one-clk pulse per completed frame (also on framing error)
// u.frame_err    : stop bit sampled low for the frame in dout
// u.busy         : FSM not idle
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int OS      = 16
) (
  input logic   clk,
  input logic   reset,
  uart_rx_if.slave u
);
  localparam int SW = $clog2(OS > SB_TICK ? OS : SB_TICK);
  localparam int NW = $clog2(DBIT);
  localparam logic [SW-1:0] S_MID  = SW'(OS / 2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(OS - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t            state_q, state_d;
  logic [SW-1:0]     s_q, s_d;
  logic [NW-1:0]     n_q, n_d;
  logic [DBIT-1:0]   b_q, b_d;
  logic [DBIT-1:0]   dout_q, dout_d;
  logic              ferr_q, ferr_d;
  logic              done_q, done_d;
  logic              rx_meta_q, rx_s_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      s_q       <= '0;
      n_q       <= '0;
      b_q       <= '0;
      dout_q    <= '0;
      ferr_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      rx_meta_q <= u.rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      s_q       <= s_d;
      n_q       <= n_d;
      b_q       <= b_d;
      dout_q    <= dout_d;
      ferr_q    <= ferr_d;
      done_q    <= done_d;
    end
  end
  // Every state except IDLE only moves on s_tick; counters are cleared on
  // state entry so a tick on the entry cycle is not counted.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    dout_d  = dout_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (u.s_tick) begin
          if (s_q == S_MID) begin
            state_d = rx_s_q ? IDLE : DATA;
            s_d     = '0;
            n_d     = '0;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (u.s_tick) begin
          if (s_q == S_BIT) begin
            s_d     = '0;
            b_d     = {rx_s_q, b_q[DBIT-1:1]};
            state_d = (n_q == N_LAST) ? STOP : DATA;
            n_d     = (n_q == N_LAST) ? n_q : n_q + 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      STOP: begin
        // Leaving at the stop-bit sample point lets a start edge right at the
        // next bit boundary be caught with no idle gap.
        if (u.s_tick) begin
          if (s_q == S_STOP) begin
            state_d = IDLE;
            dout_d  = b_q;
            ferr_d  = ~rx_s_q;
            done_d  = 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign u.dout         = dout_q;
  assign u.frame_err    = ferr_q;
  assign u.rx_done_tick = done_q;
  assign u.busy         = state_q != IDLE;
endmodule
